ofm_write_addr_controller: RTL and testbench

- Upstream stage of the OFM read address controller: after each systolic tiling, sequences OFM RAM write addresses and output-buffer selects so the tile's results land in channel-major OFM layout (filter*ofm_size^2 + row*ofm_size + col).
- That layout is what the next layer's read controller consumes.
- Tiling order: filter group (outermost), then column strip of width SYSTOLIC_SIZE, then output row (innermost). This matches the read side's row-inner tiling.

---
 rtl/ofm_write_addr_controller.sv | 252 +++++++++++++++++++++++++
 tb/tb_ofm_write_addr_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_write_addr_controller.sv
// OFM write-address sequencer: drains each systolic tile into channel-major OFM RAM; optional bound check under OFM_WRITE_BOUND_CHECK_EN.
// First write one cycle after tile_valid, tile_done after nf*width writes; tile_valid is taken only while tile_ready is high.
`timescale 1ns/1ps
module ofm_write_addr_controller #(
   parameter int SYSTOLIC_SIZE = 16,
   parameter int OFM_RAM_SIZE  = 2205619,
   localparam int AW = $clog2(OFM_RAM_SIZE),
   localparam int SW = $clog2(SYSTOLIC_SIZE)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] start_write_addr,
   input  logic [8:0]    ofm_size,
   input  logic [10:0]   num_filter,
   input  logic          tile_valid,
   output logic          tile_ready,
   output logic [AW-1:0] ofm_addr,
   output logic          write_en,
   output logic [SW-1:0] sel_filter,
   output logic [SW-1:0] sel_pixel,
   output logic          tile_done,
   output logic          layer_done
`ifdef OFM_WRITE_BOUND_CHECK_EN
   ,
   output logic          addr_error
`endif
);

   // Internal addresses are kept wide so the bound check sees the untruncated sum.
   localparam int XW = (AW > 30) ? AW + 2 : 32;
   localparam int CW = SW + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_NEXT  = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [8:0]    ofm_size_q, ofm_size_d;
   logic [17:0]   plane_q, plane_d;
   logic [8:0]    num_strips_q, num_strips_d;
   logic [10:0]   num_groups_q, num_groups_d;
   logic [8:0]    row_q, row_d;
   logic [8:0]    strip_q, strip_d;
   logic [10:0]   group_q, group_d;
   logic [8:0]    rem_px_q, rem_px_d;
   logic [10:0]   rem_f_q, rem_f_d;
   logic [XW-1:0] grp_base_q, grp_base_d;
   logic [XW-1:0] strip_base_q, strip_base_d;
   logic [XW-1:0] tile_base_q, tile_base_d;
   logic [XW-1:0] fbase_q, fbase_d;
   logic [XW-1:0] addr_q, addr_d;
   logic [SW-1:0] f_q, f_d;
   logic [SW-1:0] p_q, p_d;
   logic          write_en_q, write_en_d;
   logic          tile_done_q, tile_done_d;
   logic          layer_done_q, layer_done_d;
   logic          wr_cyc_d;
   logic          in_range_d;

   logic [9:0]    ns_w;
   logic [11:0]   ng_w;
   logic [CW-1:0] width_w, nf_w;
   logic          last_p_w, last_f_w, is_last_w;
   logic [XW-1:0] grp_step_w;

   always_comb begin
      ns_w       = ({1'b0, ofm_size} + 10'(SYSTOLIC_SIZE - 1)) >> SW;
      ng_w       = ({1'b0, num_filter} + 12'(SYSTOLIC_SIZE - 1)) >> SW;
      width_w    = (rem_px_q >= 9'(SYSTOLIC_SIZE)) ? CW'(SYSTOLIC_SIZE) : rem_px_q[CW-1:0];
      nf_w       = (rem_f_q >= 11'(SYSTOLIC_SIZE)) ? CW'(SYSTOLIC_SIZE) : rem_f_q[CW-1:0];
      last_p_w   = ({1'b0, p_q} == width_w - CW'(1));
      last_f_w   = ({1'b0, f_q} == nf_w - CW'(1));
      is_last_w  = (group_q == num_groups_q - 11'd1) && (strip_q == num_strips_q - 9'd1)
                   && (row_q == ofm_size_q - 9'd1);
      grp_step_w = XW'(plane_q) << SW;
   end

   always_comb begin
      state_d      = state_q;
      ofm_size_d   = ofm_size_q;
      plane_d      = plane_q;
      num_strips_d = num_strips_q;
      num_groups_d = num_groups_q;
      row_d        = row_q;
      strip_d      = strip_q;
      group_d      = group_q;
      rem_px_d     = rem_px_q;
      rem_f_d      = rem_f_q;
      grp_base_d   = grp_base_q;
      strip_base_d = strip_base_q;
      tile_base_d  = tile_base_q;
      fbase_d      = fbase_q;
      addr_d       = addr_q;
      f_d          = f_q;
      p_d          = p_q;
      wr_cyc_d     = 1'b0;
      tile_done_d  = 1'b0;
      layer_done_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               ofm_size_d   = ofm_size;
               plane_d      = 18'(ofm_size) * 18'(ofm_size);
               num_strips_d = ns_w[8:0];
               num_groups_d = ng_w[10:0];
               row_d        = '0;
               strip_d      = '0;
               group_d      = '0;
               rem_px_d     = ofm_size;
               rem_f_d      = num_filter;
               grp_base_d   = XW'(start_write_addr);
               strip_base_d = XW'(start_write_addr);
               tile_base_d  = XW'(start_write_addr);
               state_d      = S_WAIT;
            end
         end
         S_WAIT: begin
            if (tile_valid) begin
               addr_d   = tile_base_q;
               fbase_d  = tile_base_q;
               f_d      = '0;
               p_d      = '0;
               wr_cyc_d = 1'b1;
               state_d  = S_WRITE;
            end
         end
         S_WRITE: begin
            if (last_p_w) begin
               p_d = '0;
               if (last_f_w) begin
                  f_d          = '0;
                  tile_done_d  = 1'b1;
                  layer_done_d = is_last_w;
                  state_d      = S_NEXT;
               end else begin
                  f_d      = f_q + SW'(1);
                  fbase_d  = fbase_q + XW'(plane_q);
                  addr_d   = fbase_q + XW'(plane_q);
                  wr_cyc_d = 1'b1;
               end
            end else begin
               p_d      = p_q + SW'(1);
               addr_d   = addr_q + XW'(1);
               wr_cyc_d = 1'b1;
            end
         end
         S_NEXT: begin
            // Row is innermost, then column strip, then filter group.
            if (row_q == ofm_size_q - 9'd1) begin
               row_d = '0;
               if (strip_q == num_strips_q - 9'd1) begin
                  strip_d      = '0;
                  group_d      = group_q + 11'd1;
                  rem_px_d     = ofm_size_q;
                  rem_f_d      = rem_f_q - 11'(SYSTOLIC_SIZE);
                  grp_base_d   = grp_base_q + grp_step_w;
                  strip_base_d = grp_base_q + grp_step_w;
                  tile_base_d  = grp_base_q + grp_step_w;
               end else begin
                  strip_d      = strip_q + 9'd1;
                  rem_px_d     = rem_px_q - 9'(SYSTOLIC_SIZE);
                  strip_base_d = strip_base_q + XW'(SYSTOLIC_SIZE);
                  tile_base_d  = strip_base_q + XW'(SYSTOLIC_SIZE);
               end
            end else begin
               row_d       = row_q + 9'd1;
               tile_base_d = tile_base_q + XW'(ofm_size_q);
            end
            state_d = layer_done_q ? S_IDLE : S_WAIT;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef OFM_WRITE_BOUND_CHECK_EN
   logic addr_error_q, addr_error_d;

   always_comb begin
      in_range_d   = (addr_d < XW'(OFM_RAM_SIZE));
      addr_error_d = addr_error_q | (wr_cyc_d & ~in_range_d);
      if (state_q == S_IDLE && start) addr_error_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) addr_error_q <= 1'b0;
      else        addr_error_q <= addr_error_d;
   end

   assign addr_error = addr_error_q;
`else
   assign in_range_d = 1'b1;
`endif

   assign write_en_d = wr_cyc_d & in_range_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         ofm_size_q   <= '0;
         plane_q      <= '0;
         num_strips_q <= '0;
         num_groups_q <= '0;
         row_q        <= '0;
         strip_q      <= '0;
         group_q      <= '0;
         rem_px_q     <= '0;
         rem_f_q      <= '0;
         grp_base_q   <= '0;
         strip_base_q <= '0;
         tile_base_q  <= '0;
         fbase_q      <= '0;
         addr_q       <= '0;
         f_q          <= '0;
         p_q          <= '0;
         write_en_q   <= 1'b0;
         tile_done_q  <= 1'b0;
         layer_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ofm_size_q   <= ofm_size_d;
         plane_q      <= plane_d;
         num_strips_q <= num_strips_d;
         num_groups_q <= num_groups_d;
         row_q        <= row_d;
         strip_q      <= strip_d;
         group_q      <= group_d;
         rem_px_q     <= rem_px_d;
         rem_f_q      <= rem_f_d;
         grp_base_q   <= grp_base_d;
         strip_base_q <= strip_base_d;
         tile_base_q  <= tile_base_d;
         fbase_q      <= fbase_d;
         addr_q       <= addr_d;
         f_q          <= f_d;
         p_q          <= p_d;
         write_en_q   <= write_en_d;
         tile_done_q  <= tile_done_d;
         layer_done_q <= layer_done_d;
      end
   end

   assign tile_ready = (state_q == S_WAIT);
   assign ofm_addr   = addr_q[AW-1:0];
   assign write_en   = write_en_q;
   assign sel_filter = f_q;
   assign sel_pixel  = p_q;
   assign tile_done  = tile_done_q;
   assign layer_done = layer_done_q;

endmodule

// File: tb/tb_ofm_write_addr_controller.sv
// Scoreboard bench for ofm_write_addr_controller: expected writes are queued per tile and popped as write_en appears.
`timescale 1ns/1ps
module tb_ofm_write_addr_controller;

   localparam int S = 16;
`ifdef OFM_WRITE_BOUND_CHECK_EN
   localparam int RAM = 1000;
`else
   localparam int RAM = 2205619;
`endif
   localparam int AW = $clog2(RAM);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] start_write_addr = '0;
   logic [8:0]    ofm_size = '0;
   logic [10:0]   num_filter = '0;
   logic          tile_valid = 1'b0;
   logic          tile_ready;
   logic [AW-1:0] ofm_addr;
   logic          write_en;
   logic [3:0]    sel_filter;
   logic [3:0]    sel_pixel;
   logic          tile_done;
   logic          layer_done;
`ifdef OFM_WRITE_BOUND_CHECK_EN
   logic          addr_error;
`endif

   ofm_write_addr_controller #(.SYSTOLIC_SIZE(S), .OFM_RAM_SIZE(RAM)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_write_addr(start_write_addr),
      .ofm_size(ofm_size), .num_filter(num_filter), .tile_valid(tile_valid),
      .tile_ready(tile_ready), .ofm_addr(ofm_addr), .write_en(write_en),
      .sel_filter(sel_filter), .sel_pixel(sel_pixel), .tile_done(tile_done),
      .layer_done(layer_done)
`ifdef OFM_WRITE_BOUND_CHECK_EN
      , .addr_error(addr_error)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;
   logic [63:0] exp_q[$];

   longint m_os, m_nf, m_sa, m_row, m_strip, m_group;
   logic   m_err;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic do_start(input int os, input int nf, input int sa);
      @(posedge clk); #1;
      start = 1'b1;
      ofm_size = 9'(os);
      num_filter = 11'(nf);
      start_write_addr = AW'(sa);
      @(posedge clk); #1;
      start = 1'b0;
      m_os = os; m_nf = nf; m_sa = sa;
      m_row = 0; m_strip = 0; m_group = 0; m_err = 1'b0;
      chk("ready_after_start", 64'(tile_ready), 64'd1);
`ifdef OFM_WRITE_BOUND_CHECK_EN
      chk("err_cleared", 64'(addr_error), 64'd0);
`endif
   endtask

   // inject: 0 none, 1 tile_valid mid-write, 2 start with another config mid-write
   task automatic do_tile(input int inject);
      longint plane, base, w, nfc, a, e;
      int t0, nw;
      logic done, last;
      plane = m_os * m_os;
      base  = m_sa + m_group * S * plane + m_row * m_os + m_strip * S;
      w     = (m_os - m_strip * S) < S ? (m_os - m_strip * S) : S;
      nfc   = (m_nf - m_group * S) < S ? (m_nf - m_group * S) : S;
      last  = (m_group == (m_nf + S - 1) / S - 1) && (m_strip == (m_os + S - 1) / S - 1)
              && (m_row == m_os - 1);
      for (longint f = 0; f < nfc; f++) begin
         for (longint p = 0; p < w; p++) begin
            a = base + f * plane + p;
            if (a < RAM) begin
               e = ((a & ((64'd1 << AW) - 1)) << 8) | (f << 4) | p;
               exp_q.push_back(64'(e));
            end else begin
               m_err = 1'b1;
            end
         end
      end
      @(posedge clk); #1;
      tile_valid = 1'b1;
      t0 = cyc;
      @(posedge clk); #1;
      tile_valid = 1'b0;
      done = 1'b0;
      nw = 0;
      for (int c = 0; c < w * nfc + 10 && !done; c++) begin
         @(negedge clk);
         tile_valid = (inject == 1 && c == 5);
         start = (inject == 2 && c == 5);
         if (inject == 2 && c == 5) begin
            ofm_size = 9'd26;
            num_filter = 11'd32;
            start_write_addr = '0;
         end
         if (write_en) begin
            nw++;
            if (nw == 1) chk("ready_low_in_write", 64'(tile_ready), 64'd0);
            if (exp_q.size() == 0) chk("extra_write", 64'd1, 64'd0);
            else chk("write", 64'({ofm_addr, sel_filter, sel_pixel}), exp_q.pop_front());
         end
         if (tile_done) begin
            done = 1'b1;
            chk("done_latency", 64'(cyc - t0), 64'(1 + w * nfc));
            chk("layer_done", 64'(layer_done), 64'(last));
`ifdef OFM_WRITE_BOUND_CHECK_EN
            chk("addr_error", 64'(addr_error), 64'(m_err));
`endif
         end else if (layer_done) begin
            chk("stray_layer_done", 64'd1, 64'd0);
         end
      end
      tile_valid = 1'b0;
      start = 1'b0;
      ofm_size = 9'(m_os);
      num_filter = 11'(m_nf);
      start_write_addr = AW'(m_sa);
      if (!done) chk("tile_done_timeout", 64'd0, 64'd1);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      @(negedge clk);
      chk("ready_after_tile", 64'(tile_ready), 64'(!last));
      m_row++;
      if (m_row == m_os) begin
         m_row = 0;
         m_strip++;
         if (m_strip == (m_os + S - 1) / S) begin
            m_strip = 0;
            m_group++;
         end
      end
   endtask

   initial begin
      int nw;
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_write_en", 64'(write_en), 64'd0);
      chk("rst_tile_ready", 64'(tile_ready), 64'd0);
      chk("rst_addr", 64'(ofm_addr), 64'd0);
      chk("rst_sel", 64'({sel_filter, sel_pixel}), 64'd0);
      chk("rst_pulses", 64'({tile_done, layer_done}), 64'd0);
      rst_n = 1'b1;

      // tile_valid while IDLE is dropped
      @(posedge clk); #1;
      tile_valid = 1'b1;
      @(posedge clk); #1;
      tile_valid = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("idle_no_write", 64'(write_en), 64'd0);
      end

      // Layer A: 13x13, 16 filters, base 100; mid-write tile_valid and start on the first tiles
      do_start(13, 16, 100);
      do_tile(1);
      do_tile(2);
      for (int t = 2; t < 13; t++) do_tile(0);

      // Layer B: 26x26, 32 filters, base 0 -> 104 tiles with partial strips and two groups
      do_start(26, 32, 0);
      for (int t = 0; t < 104; t++) do_tile(0);

      // Reset on the 50th write of a tile
      do_start(13, 16, 100);
      @(posedge clk); #1;
      tile_valid = 1'b1;
      @(posedge clk); #1;
      tile_valid = 1'b0;
      nw = 0;
      for (int c = 0; c < 100 && nw < 50; c++) begin
         @(negedge clk);
         if (write_en) nw++;
      end
      chk("reached_write50", 64'(nw), 64'd50);
      rst_n = 1'b0;
      #1;
      chk("abort_write_en", 64'(write_en), 64'd0);
      chk("abort_ready", 64'(tile_ready), 64'd0);
      chk("abort_addr", 64'(ofm_addr), 64'd0);
      chk("abort_sel", 64'({sel_filter, sel_pixel}), 64'd0);
      chk("abort_pulses", 64'({tile_done, layer_done}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      tile_valid = 1'b1;
      @(posedge clk); #1;
      tile_valid = 1'b0;
      repeat (20) begin
         @(negedge clk);
         chk("post_reset_idle", 64'({write_en, tile_ready}), 64'd0);
      end

      // Recovery after a fresh start
      do_start(13, 16, 100);
      do_tile(0);

`ifdef OFM_WRITE_BOUND_CHECK_EN
      // Base 0 in a 1000-word RAM: writes from address 1014 on are suppressed
      do_start(13, 16, 0);
      do_tile(0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
